// File: rtl/antirrebote_pkg.sv
// rtl/antirrebote_pkg.sv - shared types and sizing helpers for the button debouncer
package antirrebote_pkg;

   // Debouncer FSM states
   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REPEAT,
      RELEASE_WAIT
   } estado_t;

   // Smallest counter width ever produced, even for degenerate parameter sets
   localparam int CNT_W_MIN = 1;

   // Largest of three cycle-count parameters
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Width of the shared cycle counter, sized for the largest count in use
   function automatic int cnt_w(input int a, input int b, input int c);
      int w;
      w = $clog2(max3(a, b, c));
      return (w < CNT_W_MIN) ? CNT_W_MIN : w;
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for asynchronous board inputs
module sincronizador_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture; reset loads the input's idle level so no false edge appears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/boton_antirrebote.sv
// rtl/boton_antirrebote.sv - push-button debouncer with press/release strobes and auto-repeat
module boton_antirrebote
   import antirrebote_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic             btn_sync;
   logic             s;
   estado_t          state;
   estado_t          state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             press_d;
   logic             release_d;
   logic             level_d;

   sincronizador_2ff #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (btn_sync)
   );

   // s = 1 means pressed regardless of board polarity
   assign s = btn_sync ^ ACTIVE_LOW;

   // Saturating increment keeps a long hold without repeat from wrapping
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // State and shared counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state and counter update; counter clears on every state change
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (s) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!s)                   state_d = IDLE;
            else if (cnt == DEB_LAST) state_d = HELD;
         end
         HELD: begin
            if (!s)                                state_d = RELEASE_WAIT;
            else if (REPEAT_EN && cnt == DLY_LAST) state_d = REPEAT;
         end
         REPEAT: begin
            if (!s) state_d = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (s)                    state_d = HELD;
            else if (cnt == DEB_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = cnt_inc;
      if (state_d != state)
         cnt_d = '0;
      else if (state == IDLE)
         cnt_d = '0;
      else if (state == REPEAT && cnt == PER_LAST)
         cnt_d = '0;
   end

   // Output decode from the transition about to happen, registered below
   always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      level_d   = 1'b0;
      if (state == PRESS_WAIT && state_d == HELD)
         press_d = 1'b1;
      if (state == HELD && state_d == REPEAT)
         press_d = 1'b1;
      if (state == REPEAT && state_d == REPEAT && cnt == PER_LAST)
         press_d = 1'b1;
      if (state == RELEASE_WAIT && state_d == IDLE)
         release_d = 1'b1;
      if (state_d == HELD || state_d == REPEAT || state_d == RELEASE_WAIT)
         level_d = 1'b1;
   end

   // Registered outputs so nothing combinational reaches the pins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         btn_level     <= level_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

endmodule

// File: tb/tb_boton_antirrebote.sv
// tb/tb_boton_antirrebote.sv - scoreboard bench for boton_antirrebote
module tb_boton_antirrebote;

   typedef struct {
      int cyc;
      bit is_press;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic btn_raw;
   logic lvl0, pp0, rp0;
   logic lvl1, pp1, rp1;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   m;
   int   r;
   ev_t  sb[2][$];
   int   pat[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
   int   rep_off[5] = '{20, 28, 36, 44, 52};

   boton_antirrebote #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b0),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8),
      .ACTIVE_LOW      (1'b1)
   ) dut0 (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw),
      .btn_level     (lvl0),
      .press_pulse   (pp0),
      .release_pulse (rp0)
   );

   boton_antirrebote #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8),
      .ACTIVE_LOW      (1'b1)
   ) dut1 (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw),
      .btn_level     (lvl1),
      .press_pulse   (pp1),
      .release_pulse (rp1)
   );

   always #5 clk = ~clk;

   // Edge counter: after the n-th rising edge cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic push(input int id, input int c, input bit pr);
      ev_t e;
      e.cyc = c;
      e.is_press = pr;
      sb[id].push_back(e);
   endtask

   task automatic mon(input int id, input logic p, input logic rl);
      ev_t e;
      while (sb[id].size() > 0 && sb[id][0].cyc < cyc) begin
         e = sb[id].pop_front();
         chk($sformatf("missed_pulse_dut%0d", id), cyc, e.cyc);
      end
      if (p || rl) begin
         chk($sformatf("not_both_dut%0d", id), int'(p & rl), 0);
         if (sb[id].size() == 0) begin
            chk($sformatf("unexpected_pulse_dut%0d", id), p ? 1 : 2, 0);
         end else begin
            e = sb[id].pop_front();
            chk($sformatf("pulse_cyc_dut%0d", id), cyc, e.cyc);
            chk($sformatf("pulse_kind_dut%0d", id), int'(p), int'(e.is_press));
         end
      end
   endtask

   task automatic at_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic chk_lvl(input string tag, input int exp);
      chk({tag, "_dut0"}, int'(lvl0), exp);
      chk({tag, "_dut1"}, int'(lvl1), exp);
   endtask

   // Output monitor sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         mon(0, pp0, rp0);
         mon(1, pp1, rp1);
      end
   end

   initial begin
      rst = 1'b1;
      btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_level0", int'(lvl0), 0);
      chk("rst_press0", int'(pp0), 0);
      chk("rst_release0", int'(rp0), 0);
      chk("rst_level1", int'(lvl1), 0);
      chk("rst_press1", int'(pp1), 0);
      chk("rst_release1", int'(rp1), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Clean press held 30 cycles; repeat-enabled copy fires once at +20
      @(negedge clk);
      m = cyc;
      btn_raw = 1'b0;
      push(0, m + 7, 1'b1);
      push(1, m + 7, 1'b1);
      push(1, m + 27, 1'b1);
      at_cyc(m + 6);
      chk_lvl("clean_lvl_before", 0);
      at_cyc(m + 7);
      chk_lvl("clean_lvl_after", 1);
      at_cyc(m + 30);
      btn_raw = 1'b1;
      push(0, m + 37, 1'b0);
      push(1, m + 37, 1'b0);
      at_cyc(m + 36);
      chk_lvl("clean_rel_lvl_before", 1);
      at_cyc(m + 37);
      chk_lvl("clean_rel_lvl_after", 0);
      at_cyc(m + 45);

      // Press bounce: only the final stable run is accepted
      @(negedge clk);
      m = cyc;
      for (int i = 0; i < 9; i++) begin
         at_cyc(m + i);
         btn_raw = pat[i][0];
      end
      push(0, m + 12, 1'b1);
      push(1, m + 12, 1'b1);
      at_cyc(m + 11);
      chk_lvl("bounce_lvl_before", 0);
      at_cyc(m + 12);
      chk_lvl("bounce_lvl_after", 1);
      at_cyc(m + 20);
      btn_raw = 1'b1;
      push(0, m + 27, 1'b0);
      push(1, m + 27, 1'b0);
      at_cyc(m + 35);

      // Three-cycle glitch produces nothing
      @(negedge clk);
      m = cyc;
      btn_raw = 1'b0;
      at_cyc(m + 3);
      btn_raw = 1'b1;
      at_cyc(m + 7);
      chk_lvl("glitch_lvl", 0);
      at_cyc(m + 15);

      // Long hold: five repeats on the repeat-enabled copy
      @(negedge clk);
      m = cyc;
      btn_raw = 1'b0;
      push(0, m + 7, 1'b1);
      push(1, m + 7, 1'b1);
      foreach (rep_off[i]) push(1, m + 7 + rep_off[i], 1'b1);
      at_cyc(m + 45);
      chk_lvl("repeat_lvl", 1);
      at_cyc(m + 60);
      btn_raw = 1'b1;
      push(0, m + 67, 1'b0);
      push(1, m + 67, 1'b0);
      at_cyc(m + 80);

      // Release bounce: level holds and the repeat delay restarts
      @(negedge clk);
      m = cyc;
      btn_raw = 1'b0;
      push(0, m + 7, 1'b1);
      push(1, m + 7, 1'b1);
      push(1, m + 35, 1'b1);
      at_cyc(m + 10);
      btn_raw = 1'b1;
      at_cyc(m + 12);
      btn_raw = 1'b0;
      at_cyc(m + 16);
      chk_lvl("relbounce_lvl", 1);
      at_cyc(m + 37);
      btn_raw = 1'b1;
      push(0, m + 44, 1'b0);
      push(1, m + 44, 1'b0);
      at_cyc(m + 52);

      // Reset two cycles into the press debounce, button kept held
      @(negedge clk);
      m = cyc;
      btn_raw = 1'b0;
      at_cyc(m + 5);
      rst = 1'b1;
      #1;
      chk("rstpw_press0", int'(pp0), 0);
      chk("rstpw_press1", int'(pp1), 0);
      chk_lvl("rstpw_lvl", 0);
      at_cyc(m + 7);
      rst = 1'b0;
      r = cyc;
      push(0, r + 7, 1'b1);
      push(1, r + 7, 1'b1);
      at_cyc(r + 6);
      chk_lvl("rstpw_lvl_before", 0);
      at_cyc(r + 7);
      chk_lvl("rstpw_lvl_after", 1);

      // Reset while held: level drops at once, no release strobe
      at_cyc(r + 12);
      rst = 1'b1;
      #1;
      chk_lvl("rsthold_lvl", 0);
      btn_raw = 1'b1;
      at_cyc(r + 15);
      rst = 1'b0;
      at_cyc(r + 30);
      chk_lvl("final_lvl", 0);

      chk("sb_empty_dut0", sb[0].size(), 0);
      chk("sb_empty_dut1", sb[1].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/boton_antirrebote.md
# boton_antirrebote

Debounces one mechanical push button and turns each accepted press into a single-clock `press_pulse`, with optional auto-repeat while the button is held. It sits directly upstream of the down-counter stage and drives its decrement-request input, which then sees exactly one clean edge per press. It also provides a debounced level and a release strobe for other consumers.

## Interface
- `DEBOUNCE_CYCLES`, 500_000, stable cycles needed to accept a press or a release (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_EN`, 0, 1 enables auto-repeat while held.
- `REPEAT_DELAY`, 25_000_000, cycles from the accepted press to the first repeat pulse; must be ≥ 2.
- `REPEAT_PERIOD`, 5_000_000, cycles between subsequent repeat pulses; must be ≥ 2.
- `ACTIVE_LOW`, 1, 1 means the raw button reads 0 when pressed (board KEYs).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_raw` in 1: raw, asynchronous button pin.
- `btn_level` out 1: debounced pressed level (1 = pressed).
- `press_pulse` out 1: one-cycle strobe on each accepted press and on each repeat.
- `release_pulse` out 1: one-cycle strobe on each accepted release.

## Operation
- Input path:
  - Two-flop synchronizer on `btn_raw`.
  - Then polarity normalization: `s = sync ^ ACTIVE_LOW`, so `s` = 1 means pressed.
- A single cycle counter is shared by all states, with width `$clog2` of the largest parameter. It clears on every state change.
- FSM states: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
- IDLE:
  - `btn_level` = 0.
  - `s` = 1 → PRESS_WAIT.
- PRESS_WAIT:
  - Counts while `s` = 1.
  - `s` = 0 → IDLE. This rejects the glitch and produces no pulse.
  - Count reaches `DEBOUNCE_CYCLES-1` with `s` = 1 → HELD, assert `press_pulse`, set `btn_level` = 1.
- HELD:
  - `s` = 0 → RELEASE_WAIT.
  - If `REPEAT_EN` and count reaches `REPEAT_DELAY-1` → REPEAT, assert `press_pulse`.
- REPEAT:
  - Asserts `press_pulse` every `REPEAT_PERIOD` cycles, then the counter wraps to 0.
  - `s` = 0 → RELEASE_WAIT.
- RELEASE_WAIT:
  - Counts while `s` = 0.
  - `s` = 1 → HELD, with the counter cleared. This is a release bounce, so no pulse is produced and `btn_level` stays 1. The repeat delay restarts.
  - Count reaches `DEBOUNCE_CYCLES-1` with `s` = 0 → IDLE, assert `release_pulse`, set `btn_level` = 0.
- Invariants:
  - `press_pulse` and `release_pulse` are never high in the same cycle.
  - Neither pulse is ever high two cycles in a row.
- With `REPEAT_EN` = 0, HELD never leaves except via release. The counter saturates there and does not wrap.
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Synchronizer flops reset to the released level (`ACTIVE_LOW`).
  - A button held through reset release is treated as a new press and is accepted after the full debounce.
  - Reset mid-debounce or mid-repeat aborts immediately with no pulse.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Press latency:
  - Let edge k be the first clock edge at which `btn_raw` is held pressed and stable.
  - `press_pulse` is high for exactly the cycle following edge k+2+`DEBOUNCE_CYCLES`: 2 synchronizer cycles plus the debounce count.
- Release latency: the same formula, applied to `release_pulse`.
- First repeat: `REPEAT_DELAY` cycles after the initial `press_pulse`.
- Later repeats: every `REPEAT_PERIOD` cycles after that.
- `btn_level` changes in the same cycle as the corresponding pulse.
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive stable samples never changes `btn_level`.

## Structure
- Package `antirrebote_pkg` holds:
  - the `estado_t` enum (IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT);
  - the `max3` constant function used for counter sizing;
  - the `CNT_W` localparam helper.
- Sub-module `sincronizador_2ff` holds the reset-value parameterized 2-flop synchronizer. It is reusable for other asynchronous board inputs.
- The FSM, counter and output registers live in `boton_antirrebote`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `ACTIVE_LOW`=1.
- Clean press:
  - Stimulus: drive `btn_raw` 1→0 and hold for 30 cycles, with `REPEAT_EN`=0.
  - Response: exactly one `press_pulse`, 6 cycles after the first sampled 0; `btn_level`=1 from that cycle.
  - Then drive `btn_raw` back to 1: exactly one `release_pulse`, 6 cycles later; `btn_level`=0.
- Bounce rejection:
  - Stimulus: press pattern 0,1,0,0,1,0,0,0,0 (per cycle).
  - Response: a single `press_pulse`, only after the final run of four stable 0s has passed through the synchronizer; no pulse earlier.
- Glitch:
  - Stimulus: a 3-cycle 0 pulse.
  - Response: no `press_pulse` and no `release_pulse`; `btn_level` stays 0.
- Auto-repeat:
  - Stimulus: `REPEAT_EN`=1, hold for 60 cycles.
  - Response: pulses at offsets 0, 20, 28, 36, 44, 52 relative to the first pulse, i.e. 6 pulses total; release stops the repeats.
- Release bounce:
  - Stimulus: while held, drive 1,1,0 and then stay 0.
  - Response: no `release_pulse`; `btn_level` stays 1; the repeat delay restarts.
- Reset:
  - Stimulus: assert `rst` two cycles into PRESS_WAIT while the button is held.
  - Response: all outputs 0 immediately.
  - After `rst` deasserts with the button still held: `press_pulse` occurs 6 cycles after the first post-reset edge.
